au_project_select_driver: RTL and testbench
===========================================

// Module: au_project_select_driver
// PURPOSE
//  Host-side sequencer for the project-selection emulation interface. It drives
//  sel_rst_n / sel_inc / sel_ena into the board's project selector. On start it
//  resets the selector, then issues project_num increment pulses, waits a settle
//  time, and asserts sel_ena. Used on FPGA top levels and benches to select a
//  design instead of hand-toggling pins.
// PARAMETERS
//  NUM_WIDTH      8   width of project_num; up to 2**NUM_WIDTH-1 increments
//  PULSE_CYCLES   4   clk cycles per pulse phase (each high and each low); >=1
//  SETTLE_CYCLES  8   clk cycles after the last increment before sel_ena rises; >=1
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous active-low reset
//  start        in   1          1-cycle request: select project_num
//  project_num  in   NUM_WIDTH  target project index; sampled when start is accepted
//  deselect     in   1          1-cycle request: drop the active or in-progress selection
//  sel_rst_n    out  1          selector reset, active low
//  sel_inc      out  1          selector increment pulse, active high
//  sel_ena      out  1          selector enable
//  busy         out  1          sequence in progress (RST..SETTLE)
//  done         out  1          1-cycle strobe on the cycle sel_ena first rises
//  selected     out  1          equals sel_ena; held while ACTIVE
// BEHAVIOUR
//  - All outputs are registered. On reset: sel_rst_n=0, sel_inc=0, sel_ena=0,
//    busy=0, done=0, selected=0, FSM=IDLE, phase counter=0, increment counter=0.
//  - FSM states:
//    - IDLE: sel_rst_n=0.
//    - RST_LO: sel_rst_n=0 for P cycles.
//    - RST_HI: sel_rst_n=1 for P cycles.
//    - INC_HI: sel_inc=1 for P cycles.
//    - INC_LO: sel_inc=0 for P cycles.
//    - SETTLE: S cycles.
//    - ACTIVE: sel_ena=1.
//    P=PULSE_CYCLES, S=SETTLE_CYCLES. sel_rst_n=1 from RST_HI through ACTIVE.
//  - IDLE + start: latch project_num into N and go to RST_LO.
//  - RST_LO -> RST_HI after P cycles.
//  - RST_HI -> INC_HI after P cycles if N!=0, else -> SETTLE.
//  - INC_HI -> INC_LO after P cycles.
//  - INC_LO -> INC_HI after P cycles if fewer than N pulses have been issued, else -> SETTLE.
//  - SETTLE -> ACTIVE after S cycles. The entry cycle asserts sel_ena=1, selected=1, done=1.
//  - Exactly N rising edges of sel_inc occur per sequence. sel_inc is never high
//    while sel_rst_n=0 or sel_ena=1.
//  - Latency: if start is sampled at edge k, sel_ena and done are first 1 after
//    edge k+L, with L = 2P(N+1)+S+1. Defaults, N=17: L=153.
//  - busy=1 in RST_LO, RST_HI, INC_HI, INC_LO, SETTLE; 0 in IDLE and ACTIVE.
//  - start while busy: ignored, and project_num is not re-sampled.
//  - start in ACTIVE: reselect. Next cycle sel_ena=0 and the FSM is in RST_LO with the
//    new N. Same latency L, measured from that start.
//  - deselect in any non-IDLE state: next cycle the FSM is IDLE with sel_ena=0,
//    sel_inc=0, sel_rst_n=0, busy=0. A partial increment pulse is truncated.
//  - deselect and start in the same cycle: deselect wins and start is dropped.
//  - deselect in IDLE: no effect.
//  - Counters are sized for max(P,S) and 2**NUM_WIDTH-1 with no wrap.
//    N = all-ones yields exactly 2**NUM_WIDTH-1 pulses.
//  - Asynchronous reset mid-sequence forces the reset values immediately.
// TESTING
//  1. Defaults, start with project_num=17 -> 17 sel_inc rising edges, each 4 high /
//     4 low; sel_ena and done rise 153 cycles after start; done lasts 1 cycle.
//  2. project_num=0 -> no sel_inc pulse; sel_rst_n low 4, high 4; sel_ena at L=17.
//  3. Second start with num=5 while busy at cycle 20 -> ignored; 17 pulses, L=153.
//  4. Start with num=3 while ACTIVE (after num=17) -> sel_ena drops next cycle;
//     sel_rst_n low 4 cycles; 3 pulses; sel_ena back at L=41.
//  5. deselect during the 6th INC_HI -> next cycle IDLE, sel_inc=0, sel_rst_n=0,
//     busy=0; start and deselect in the same cycle -> stays IDLE.
//  6. NUM_WIDTH=3, num=7, P=1, S=1 -> 7 pulses, L=18; assert rst_n mid-SETTLE ->
//     all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/au_project_select_driver_if.sv
// Host-side bundle for the project selector sequencer: request inputs,
// selector drive lines, status strobes and the FSM state for debug.
interface au_project_select_driver_if #(
  parameter int NUM_WIDTH = 8
);
   // start and deselect are single-cycle requests with no ready: start is taken
   // only in IDLE or ACTIVE (busy=1 means it is dropped); deselect always wins.
   logic                 start;
   logic [NUM_WIDTH-1:0] project_num;
   logic                 deselect;
   logic                 sel_rst_n;
   logic                 sel_inc;
   logic                 sel_ena;
   logic                 busy;
   logic                 done;
   logic                 selected;
   logic [2:0]           fsm_state;

   modport master (
      output start, project_num, deselect,
      input  sel_rst_n, sel_inc, sel_ena, busy, done, selected, fsm_state
   );

   modport slave (
      input  start, project_num, deselect,
      output sel_rst_n, sel_inc, sel_ena, busy, done, selected, fsm_state
   );
endinterface

// File: rtl/au_project_select_driver.sv
// Sequencer that resets the board's project selector, clocks in project_num
// increment pulses, waits a settle time and then enables the selected design.
module au_project_select_driver #(
   parameter int NUM_WIDTH     = 8,
   parameter int PULSE_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   au_project_select_driver_if.slave    bus
);

   localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0]        P_LAST = CW'(PULSE_CYCLES - 1);
   // Settle counts one extra cycle so sel_ena lands on the registered edge after S full cycles.
   localparam logic [CW-1:0]        S_LAST = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0]        ONE_C  = CW'(1);
   localparam logic [NUM_WIDTH-1:0] ONE_N  = NUM_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RST_LO = 3'd1,
      S_RST_HI = 3'd2,
      S_INC_HI = 3'd3,
      S_INC_LO = 3'd4,
      S_SETTLE = 3'd5,
      S_ACTIVE = 3'd6
   } state_t;

   state_t               state;
   logic [CW-1:0]        phase_cnt;
   logic [NUM_WIDTH-1:0] inc_cnt;
   logic [NUM_WIDTH-1:0] n_reg;

   assign bus.fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         phase_cnt     <= '0;
         inc_cnt       <= '0;
         n_reg         <= '0;
         bus.sel_rst_n <= 1'b0;
         bus.sel_inc   <= 1'b0;
         bus.sel_ena   <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.selected  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (bus.deselect) begin
            // Also covers IDLE so a coincident start is dropped there too.
            state         <= S_IDLE;
            phase_cnt     <= '0;
            inc_cnt       <= '0;
            bus.sel_rst_n <= 1'b0;
            bus.sel_inc   <= 1'b0;
            bus.sel_ena   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.selected  <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_ACTIVE: begin
                  if (bus.start) begin
                     n_reg         <= bus.project_num;
                     state         <= S_RST_LO;
                     phase_cnt     <= '0;
                     inc_cnt       <= '0;
                     bus.sel_rst_n <= 1'b0;
                     bus.sel_ena   <= 1'b0;
                     bus.selected  <= 1'b0;
                     bus.busy      <= 1'b1;
                  end
               end
               S_RST_LO: begin
                  if (phase_cnt == P_LAST) begin
                     phase_cnt     <= '0;
                     state         <= S_RST_HI;
                     bus.sel_rst_n <= 1'b1;
                  end else begin
                     phase_cnt <= phase_cnt + ONE_C;
                  end
               end
               S_RST_HI: begin
                  if (phase_cnt == P_LAST) begin
                     phase_cnt <= '0;
                     if (n_reg != '0) begin
                        state       <= S_INC_HI;
                        bus.sel_inc <= 1'b1;
                        inc_cnt     <= inc_cnt + ONE_N;
                     end else begin
                        state <= S_SETTLE;
                     end
                  end else begin
                     phase_cnt <= phase_cnt + ONE_C;
                  end
               end
               S_INC_HI: begin
                  if (phase_cnt == P_LAST) begin
                     phase_cnt   <= '0;
                     state       <= S_INC_LO;
                     bus.sel_inc <= 1'b0;
                  end else begin
                     phase_cnt <= phase_cnt + ONE_C;
                  end
               end
               S_INC_LO: begin
                  if (phase_cnt == P_LAST) begin
                     phase_cnt <= '0;
                     // inc_cnt already holds the number of pulses issued; it never exceeds n_reg.
                     if (inc_cnt == n_reg) begin
                        state <= S_SETTLE;
                     end else begin
                        state       <= S_INC_HI;
                        bus.sel_inc <= 1'b1;
                        inc_cnt     <= inc_cnt + ONE_N;
                     end
                  end else begin
                     phase_cnt <= phase_cnt + ONE_C;
                  end
               end
               S_SETTLE: begin
                  if (phase_cnt == S_LAST) begin
                     phase_cnt    <= '0;
                     state        <= S_ACTIVE;
                     bus.sel_ena  <= 1'b1;
                     bus.selected <= 1'b1;
                     bus.done     <= 1'b1;
                     bus.busy     <= 1'b0;
                  end else begin
                     phase_cnt <= phase_cnt + ONE_C;
                  end
               end
               default: begin
                  state         <= S_IDLE;
                  phase_cnt     <= '0;
                  inc_cnt       <= '0;
                  bus.sel_rst_n <= 1'b0;
                  bus.sel_inc   <= 1'b0;
                  bus.sel_ena   <= 1'b0;
                  bus.busy      <= 1'b0;
                  bus.selected  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_au_project_select_driver.sv
// Bench for au_project_select_driver: a default-parameter instance driven by
// directed and random selections, plus a minimal-timing instance (W=3, P=1, S=1).
module tb_au_project_select_driver;

   localparam int P = 4;
   localparam int S = 8;
   localparam int NO_CUT = 1 << 30;

   logic clk;
   logic rst_n;
   logic rst_n_b;

   int n_checks = 0;
   int n_fail   = 0;

   au_project_select_driver_if #(.NUM_WIDTH(8)) bus_a ();
   au_project_select_driver_if #(.NUM_WIDTH(3)) bus_b ();

   au_project_select_driver #(.NUM_WIDTH(8), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   au_project_select_driver #(.NUM_WIDTH(3), .PULSE_CYCLES(1), .SETTLE_CYCLES(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n_b),
      .bus   (bus_b.slave)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vectors: {sel_rst_n, sel_inc, sel_ena, selected, busy, done}
   function automatic logic [5:0] obs_a();
      return {bus_a.sel_rst_n, bus_a.sel_inc, bus_a.sel_ena, bus_a.selected, bus_a.busy, bus_a.done};
   endfunction

   function automatic logic [5:0] obs_b();
      return {bus_b.sel_rst_n, bus_b.sel_inc, bus_b.sel_ena, bus_b.selected, bus_b.busy, bus_b.done};
   endfunction

   // Reference: expected outputs j cycles after the edge that accepted start,
   // from the timing rules alone. Outputs are all zero from cycle 'cut' on (deselect).
   function automatic logic [5:0] model(int j, int n, int p, int s, int cut);
      int   l;
      logic rstn, inc, ena, bsy, dn;
      l = 2 * p * (n + 1) + s + 1;
      if (j >= cut) return 6'b0;
      rstn = (j >= p);
      inc  = 1'b0;
      if (j >= 2 * p && j < 2 * p * (n + 1))
         inc = (((j - 2 * p) % (2 * p)) < p);
      ena = (j >= l);
      bsy = (j < l);
      dn  = (j == l);
      return {rstn, inc, ena, ena, bsy, dn};
   endfunction

   // Driver tasks
   task automatic do_start_a(input int num);
      @(negedge clk);
      bus_a.start       = 1'b1;
      bus_a.project_num = 8'(num);
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
   endtask

   // Observes dut_a cycle by cycle after an accepted start. inj_kind at cycle inj_j:
   // 0 none, 1 start(inj_num), 2 deselect, 3 start+deselect.
   task automatic run_seq_a(input string name, input int n, input int jmax,
                            input int inj_kind, input int inj_j, input int inj_num);
      int         cut;
      int         rises, exp_rises;
      logic       prev_inc, prev_exp_inc;
      logic [5:0] exp_v, got_v;
      cut       = (inj_kind >= 2) ? inj_j + 1 : NO_CUT;
      rises     = 0;
      exp_rises = 0;
      prev_inc     = 1'b0;
      prev_exp_inc = 1'b0;
      for (int j = 0; j <= jmax; j++) begin
         @(negedge clk);
         bus_a.start    = 1'b0;
         bus_a.deselect = 1'b0;
         exp_v = model(j, n, P, S, cut);
         got_v = obs_a();
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: outputs got %b expected %b", name, j, got_v, exp_v);
         end
         if (got_v[4] && !prev_inc) rises++;
         if (exp_v[4] && !prev_exp_inc) exp_rises++;
         prev_inc     = got_v[4];
         prev_exp_inc = exp_v[4];
         if (j == inj_j && inj_kind != 0) begin
            if (inj_kind == 1 || inj_kind == 3) begin
               bus_a.start       = 1'b1;
               bus_a.project_num = 8'(inj_num);
            end
            if (inj_kind >= 2) bus_a.deselect = 1'b1;
         end
      end
      n_checks++;
      if (rises != exp_rises) begin
         n_fail++;
         $display("FAIL %s pulse count: got %0d expected %0d", name, rises, exp_rises);
      end
   endtask

   function automatic int lat(int n, int p, int s);
      return 2 * p * (n + 1) + s + 1;
   endfunction

   // Tests
   task automatic test_reset();
      rst_n   = 1'b0;
      rst_n_b = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (obs_a() !== 6'b0 || bus_a.fsm_state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_a: outputs %b state %0d expected 000000 state 0", obs_a(), bus_a.fsm_state);
      end
      n_checks++;
      if (obs_b() !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_b: outputs %b expected 000000", obs_b());
      end
      rst_n   = 1'b1;
      rst_n_b = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_17();
      do_start_a(17);
      run_seq_a("basic_n17", 17, lat(17, P, S) + 3, 0, 0, 0);
   endtask

   task automatic test_reselect();
      // dut_a is ACTIVE with N=17 here
      do_start_a(3);
      run_seq_a("reselect_n3", 3, lat(3, P, S) + 3, 0, 0, 0);
   endtask

   task automatic test_zero();
      do_start_a(0);
      run_seq_a("zero_n0", 0, lat(0, P, S) + 3, 0, 0, 0);
   endtask

   task automatic test_start_while_busy();
      do_start_a(17);
      run_seq_a("busy_start_ignored", 17, lat(17, P, S) + 2, 1, 20, 5);
   endtask

   task automatic test_deselect();
      // Sixth increment pulse is high over cycles 2P+10P .. 2P+10P+P-1
      do_start_a(17);
      run_seq_a("deselect_inc6", 17, 2 * P + 10 * P + 8, 2, 2 * P + 10 * P + 1, 0);
      @(negedge clk);
      bus_a.start       = 1'b1;
      bus_a.deselect    = 1'b1;
      bus_a.project_num = 8'd9;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         bus_a.start    = 1'b0;
         bus_a.deselect = 1'b0;
         n_checks++;
         if (obs_a() !== 6'b0) begin
            n_fail++;
            $display("FAIL idle_start_deselect cycle %0d: outputs %b expected 000000", j, obs_a());
         end
      end
      // Coincident start+deselect while ACTIVE also returns to IDLE
      do_start_a(2);
      run_seq_a("active_start_deselect", 2, lat(2, P, S) + 6, 3, lat(2, P, S) + 2, 6);
   endtask

   task automatic test_max_count();
      do_start_a(255);
      run_seq_a("max_n255", 255, lat(255, P, S) + 2, 0, 0, 0);
      @(negedge clk);
      bus_a.deselect = 1'b1;
      @(negedge clk);
      bus_a.deselect = 1'b0;
   endtask

   task automatic test_random();
      int n, kind, l, inj_j;
      for (int it = 0; it < 6; it++) begin
         n    = $urandom_range(0, 40);
         kind = $urandom_range(0, 3);
         l    = lat(n, P, S);
         inj_j = $urandom_range(0, l - 1);
         do_start_a(n);
         run_seq_a($sformatf("random_%0d", it), n, (kind >= 2) ? inj_j + 5 : l + 2,
                   kind, inj_j, $urandom_range(0, 255));
         @(negedge clk);
         bus_a.deselect = 1'b1;
         @(negedge clk);
         bus_a.deselect = 1'b0;
      end
   endtask

   task automatic test_small_config();
      logic [5:0] exp_v;
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         bus_b.start       = 1'b1;
         bus_b.project_num = 3'd7;
         @(posedge clk);
         #1;
         bus_b.start = 1'b0;
         for (int j = 0; j <= ((pass == 0) ? lat(7, 1, 1) + 2 : 2 * 8); j++) begin
            @(negedge clk);
            exp_v = model(j, 7, 1, 1, NO_CUT);
            n_checks++;
            if (obs_b() !== exp_v) begin
               n_fail++;
               $display("FAIL small_n7 pass %0d cycle %0d: outputs %b expected %b", pass, j, obs_b(), exp_v);
            end
         end
      end
      // Now in SETTLE: reset asynchronously between clock edges
      #2;
      rst_n_b = 1'b0;
      #1;
      n_checks++;
      if (obs_b() !== 6'b0) begin
         n_fail++;
         $display("FAIL small_async_reset: outputs %b expected 000000", obs_b());
      end
      @(negedge clk);
      rst_n_b = 1'b1;
   endtask

   initial begin
      bus_a.start       = 1'b0;
      bus_a.deselect    = 1'b0;
      bus_a.project_num = '0;
      bus_b.start       = 1'b0;
      bus_b.deselect    = 1'b0;
      bus_b.project_num = '0;
      test_reset();
      test_basic_17();
      test_reselect();
      test_zero();
      test_start_while_busy();
      test_deselect();
      test_max_count();
      test_random();
      test_small_config();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
